// File: rtl/mem_ctrl.sv
// Byte-serial RAM sequencer shared by instruction fetch and the MEM stage.
// MEM has fixed priority; each granted request ends with a one-cycle done pulse.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              owner_mem_q, owner_mem_d;
    logic [31:0]       result_q, result_d;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic [2:0]        idx_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [1:0]        byte_sel;
    logic [2:0]        mem_bytes;

    assign idx_nxt  = idx_q + 3'd1;
    assign addr_nxt = base_q + ADDR_W'(idx_nxt);
    // ram_din carries the byte addressed one cycle earlier
    assign byte_sel = 2'(idx_q - 3'd1);

    always_comb begin
        unique case (mem_len)
            2'b00:   mem_bytes = 3'd1;
            2'b01:   mem_bytes = 3'd2;
            default: mem_bytes = 3'd4;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        owner_mem_d = owner_mem_q;
        result_d    = result_q;
        ram_addr_d  = '0;
        ram_wr_d    = 1'b0;
        ram_dout_d  = 8'h00;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;

        unique case (state_q)
            StIdle: begin
                idx_d    = 3'd0;
                result_d = 32'h0;
                if (mem_req) begin
                    owner_mem_d = 1'b1;
                    base_d      = mem_addr;
                    len_d       = mem_bytes;
                    wdata_d     = mem_wdata;
                    ram_addr_d  = mem_addr;
                    if (mem_we) begin
                        state_d    = StWrite;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata[7:0];
                    end else begin
                        state_d = StRead;
                    end
                end else if (if_req) begin
                    owner_mem_d = 1'b0;
                    base_d      = if_addr;
                    len_d       = 3'd4;
                    ram_addr_d  = if_addr;
                    state_d     = StRead;
                end
            end
            StRead: begin
                if (idx_q != 3'd0) begin
                    result_d[{byte_sel, 3'b000} +: 8] = ram_din;
                end
                if (idx_q == len_q) begin
                    state_d = StDone;
                    if (owner_mem_q) begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = result_d;
                    end else begin
                        if_done_d = 1'b1;
                        if_data_d = result_d;
                    end
                end else begin
                    idx_d = idx_nxt;
                    // The last increment lands on the drain cycle, which drives no address
                    if (idx_nxt != len_q) begin
                        ram_addr_d = addr_nxt;
                    end
                end
            end
            StWrite: begin
                if (idx_nxt == len_q) begin
                    state_d    = StDone;
                    mem_done_d = 1'b1;
                end else begin
                    idx_d      = idx_nxt;
                    ram_addr_d = addr_nxt;
                    ram_wr_d   = 1'b1;
                    ram_dout_d = wdata_q[{idx_nxt[1:0], 3'b000} +: 8];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            idx_q       <= 3'd0;
            len_q       <= 3'd0;
            base_q      <= '0;
            wdata_q     <= 32'h0;
            owner_mem_q <= 1'b0;
            result_q    <= 32'h0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'h00;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            owner_mem_q <= owner_mem_d;
            result_q    <= result_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wr    = ram_wr_q;
    assign ram_dout  = ram_dout_q;
    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-level RAM traffic, done timing, arbitration,
// reset abort and address wrap, all against hand-computed values.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    logic [7:0]  ram [0:4095];

    int checks = 0;
    int errors = 0;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_data   (if_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_len   (mem_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din)
    );

    always #5 clk = ~clk;

    // Read-only RAM model with one cycle of read latency, indexed by the low 12 address bits
    always @(posedge clk) ram_din <= ram[ram_addr[11:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller raises the request in an IDLE cycle; the first tick is the grant edge.
    task automatic run_seq(input logic [31:0] base, input int n, input bit wr,
                           input logic [31:0] wdata, input bit is_mem,
                           input logic [31:0] exp_data);
        for (int i = 0; i < n; i++) begin
            tick();
            check("addr", ram_addr, base + 32'(i));
            check("wr", {31'b0, ram_wr}, {31'b0, wr});
            if (wr) check("dout", {24'b0, ram_dout}, {24'b0, wdata[8*i +: 8]});
            check("early_done", {30'b0, if_done, mem_done}, 32'h0);
        end
        if (!wr) begin
            tick();
            check("drain_wr", {31'b0, ram_wr}, 32'h0);
            check("drain_done", {30'b0, if_done, mem_done}, 32'h0);
        end
        tick();
        check("done", {31'b0, is_mem ? mem_done : if_done}, 32'h1);
        check("other_done", {31'b0, is_mem ? if_done : mem_done}, 32'h0);
        check("done_wr", {31'b0, ram_wr}, 32'h0);
        if (!wr) check("data", is_mem ? mem_rdata : if_data, exp_data);
        if (is_mem) mem_req = 1'b0;
        else        if_req  = 1'b0;
        tick();
        check("idle_done", {30'b0, if_done, mem_done}, 32'h0);
        check("idle_addr", ram_addr, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_len = 2'b00; mem_addr = '0; mem_wdata = '0;
        tick();
        tick();
        check("rst_addr", ram_addr, 32'h0);
        check("rst_wr", {31'b0, ram_wr}, 32'h0);
        check("rst_dout", {24'b0, ram_dout}, 32'h0);
        check("rst_done", {30'b0, if_done, mem_done}, 32'h0);
        check("rst_if_data", if_data, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        rst = 1'b1;
        tick();

        // IF fetch
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h10; ram[12'h103] = 8'h00;
        if_req = 1'b1; if_addr = 32'h100;
        run_seq(32'h100, 4, 1'b0, 32'h0, 1'b0, 32'h0010_0513);

        // Byte and halfword loads
        ram[12'h030] = 8'h5A; ram[12'h031] = 8'hF0;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h31;
        run_seq(32'h31, 1, 1'b0, 32'h0, 1'b1, 32'h0000_00F0);
        mem_req = 1'b1; mem_len = 2'b01; mem_addr = 32'h30;
        run_seq(32'h30, 2, 1'b0, 32'h0, 1'b1, 32'h0000_F05A);

        // Word store; load data must survive it
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h2000;
        mem_wdata = 32'hDEAD_BEEF;
        run_seq(32'h2000, 4, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0);
        check("store_keeps_rdata", mem_rdata, 32'h0000_F05A);
        check("if_data_held", if_data, 32'h0010_0513);

        // Contention: MEM first, one IDLE cycle, then IF
        ram[12'h000] = 8'h11; ram[12'h001] = 8'h22; ram[12'h002] = 8'h33; ram[12'h003] = 8'h44;
        ram[12'h100] = 8'h93; ram[12'h101] = 8'h00; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'h2000;
        if_req = 1'b1; if_addr = 32'h100;
        run_seq(32'h2000, 4, 1'b0, 32'h0, 1'b1, 32'h4433_2211);
        check("if_waited", if_data, 32'h0010_0513);
        run_seq(32'h100, 4, 1'b0, 32'h0, 1'b0, 32'h0000_0093);

        // Reset during the second store byte
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h2000;
        mem_wdata = 32'h1234_5678;
        tick();
        check("abort_b0", {24'b0, ram_dout}, 32'h78);
        tick();
        check("abort_b1_addr", ram_addr, 32'h2001);
        check("abort_b1_wr", {31'b0, ram_wr}, 32'h1);
        rst = 1'b0;
        tick();
        check("abort_wr", {31'b0, ram_wr}, 32'h0);
        check("abort_addr", ram_addr, 32'h0);
        check("abort_done", {30'b0, if_done, mem_done}, 32'h0);
        check("abort_rdata", mem_rdata, 32'h0);
        check("abort_if_data", if_data, 32'h0);
        rst = 1'b1; mem_req = 1'b0;
        tick();
        check("post_abort_done", {30'b0, if_done, mem_done}, 32'h0);
        check("post_abort_wr", {31'b0, ram_wr}, 32'h0);
        if_req = 1'b1; if_addr = 32'h100;
        run_seq(32'h100, 4, 1'b0, 32'h0, 1'b0, 32'h0000_0093);

        // Reserved length treated as 4 bytes, address wraps through zero
        ram[12'hFFE] = 8'hA1; ram[12'hFFF] = 8'hB2; ram[12'h000] = 8'hC3; ram[12'h001] = 8'hD4;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b11; mem_addr = 32'hFFFF_FFFE;
        run_seq(32'hFFFF_FFFE, 4, 1'b0, 32'h0, 1'b1, 32'hD4C3_B2A1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
